// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3, one bit
// per clock) with a start/done handshake, overflow flag and an optional
// leading-zero blanking mask.
// Optional feature macro: BIN2BCD_LEADING_BLANK_EN (builds the blanking mask;
// without it, blank is tied to zero). The port list is the same in both builds.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   sh;
  logic [BW-1:0]      scratch;
  logic               ovf_acc;
  logic [CW-1:0]      cnt;
  logic [BW-1:0]      corr;
  logic [DIGITS-1:0]  mask;

  // Add 3 to every digit that is 5 or more; digits are corrected in parallel.
  function automatic logic [BW-1:0] add3_correct(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Correction stage feeding the shift: one add-3 level regardless of WIDTH.
  always_comb begin
    corr = add3_correct(scratch);
  end

`ifdef BIN2BCD_LEADING_BLANK_EN
  logic zero_run;

  // Blank digit i (i >= 1) when it and every higher digit are zero.
  always_comb begin
    mask     = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (scratch[4*i +: 4] == 4'd0);
      mask[i]  = zero_run;
    end
  end
`else
  // No blanking: the mask is constant zero.
  always_comb begin
    mask = '0;
  end
`endif

  // Next-state logic: IDLE -> SHIFT on start, WIDTH shifts, one LOAD cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered outputs; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
      blank   <= '0;
      sh      <= '0;
      scratch <= '0;
      ovf_acc <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state == LOAD);
      case (state)
        IDLE: begin
          if (start) begin
            sh      <= bin;
            scratch <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          // {corr, sh} shifted left; the bit leaving corr is a lost high digit.
          scratch <= {corr[BW-2:0], sh[WIDTH-1]};
          sh      <= sh << 1;
          ovf_acc <= ovf_acc | corr[BW-1];
          cnt     <= cnt + CW'(1);
        end
        LOAD: begin
          bcd   <= scratch;
          ovf   <= ovf_acc;
          blank <= mask;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: a 3-digit instance (a) and a
// 2-digit instance (b) for the overflow cases, both WIDTH=8.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_LEADING_BLANK_EN
  localparam logic [2:0] BL_ONE = 3'b110;
  localparam logic [2:0] BL_TWO = 3'b100;
`else
  localparam logic [2:0] BL_ONE = 3'b000;
  localparam logic [2:0] BL_TWO = 3'b000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0;
  logic [7:0]  bin_a = 8'd0;
  logic        busy_a, done_a, ovf_a;
  logic [11:0] bcd_a;
  logic [2:0]  blank_a;
  logic        start_b = 1'b0;
  logic [7:0]  bin_b = 8'd0;
  logic        busy_b, done_b, ovf_b;
  logic [7:0]  bcd_b;
  logic [1:0]  blank_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a), .blank(blank_a)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b), .blank(blank_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done on instance a after the accepting edge; n=-1 on timeout.
  task automatic wait_done_a(output int n, output int busy_cnt);
    bit seen;
    seen = 0; n = 0; busy_cnt = 0;
    while (!seen && n < 30) begin
      if (busy_a) busy_cnt++;
      tick();
      n++;
      if (done_a) seen = 1;
    end
    if (!seen) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({busy_a, done_a, bcd_a, ovf_a, blank_a} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_a: got busy=%b done=%b bcd=%h ovf=%b blank=%b, want all 0",
               busy_a, done_a, bcd_a, ovf_a, blank_a);
    end
    n_checks++;
    if ({busy_b, done_b, bcd_b, ovf_b, blank_b} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_b: got busy=%b done=%b bcd=%h ovf=%b blank=%b, want all 0",
               busy_b, done_b, bcd_b, ovf_b, blank_b);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_convert_255();
    int n, bc;
    bin_a = 8'd255; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_checks++;
    if (busy_a !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_start: got %b, want 1", busy_a);
    end
    wait_done_a(n, bc);
    n_checks++;
    if (n != 9) begin n_fail++; $display("FAIL latency_255: got %0d, want 9", n); end
    n_checks++;
    if (bc != 9) begin n_fail++; $display("FAIL busy_len_255: got %0d, want 9", bc); end
    n_checks++;
    if ({bcd_a, ovf_a, blank_a} !== {12'h255, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL result_255: got bcd=%h ovf=%b blank=%b, want 255 0 000", bcd_a, ovf_a, blank_a);
    end
    n_checks++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL busy_in_done: got %b, want 0", busy_a); end
    tick();
    n_checks++;
    if ({done_a, bcd_a} !== {1'b0, 12'h255}) begin
      n_fail++; $display("FAIL done_pulse_hold: got done=%b bcd=%h, want 0 255", done_a, bcd_a);
    end
  endtask

  task automatic test_small_values();
    int n, bc;
    bin_a = 8'd0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a(n, bc);
    n_checks++;
    if ({bcd_a, ovf_a, blank_a} !== {12'h000, 1'b0, BL_ONE} || n != 9) begin
      n_fail++;
      $display("FAIL zero: got bcd=%h ovf=%b blank=%b lat=%0d, want 000 0 %b 9",
               bcd_a, ovf_a, blank_a, n, BL_ONE);
    end
    tick();
    bin_a = 8'd7; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a(n, bc);
    n_checks++;
    if ({bcd_a, ovf_a, blank_a} !== {12'h007, 1'b0, BL_ONE} || n != 9) begin
      n_fail++;
      $display("FAIL seven: got bcd=%h ovf=%b blank=%b lat=%0d, want 007 0 %b 9",
               bcd_a, ovf_a, blank_a, n, BL_ONE);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] vin  [3] = '{8'd199, 8'd99, 8'd255};
    logic [7:0] vbcd [3] = '{8'h99, 8'h99, 8'h55};
    logic       vovf [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      int n;
      bit seen;
      bin_b = vin[k]; start_b = 1'b1;
      tick();
      start_b = 1'b0;
      n = 0; seen = 0;
      while (!seen && n < 30) begin
        tick(); n++;
        if (done_b) seen = 1;
      end
      n_checks++;
      if (!seen || {bcd_b, ovf_b, blank_b} !== {vbcd[k], vovf[k], 2'b00}) begin
        n_fail++;
        $display("FAIL ovf_%0d: got done=%b bcd=%h ovf=%b blank=%b, want 1 %h %b 00",
                 vin[k], seen, bcd_b, ovf_b, blank_b, vbcd[k], vovf[k]);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    int dones, falls;
    logic prev;
    logic [11:0] bcd_at;
    logic [2:0]  blank_at;
    dones = 0; falls = 0; bcd_at = 12'hfff; blank_at = 3'b111;
    bin_a = 8'd42; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick();
    bin_a = 8'd200; start_a = 1'b1;
    prev = busy_a;
    tick();
    start_a = 1'b0;
    if (prev && !busy_a) falls++;
    prev = busy_a;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (prev && !busy_a) falls++;
      prev = busy_a;
      if (done_a) begin dones++; bcd_at = bcd_a; blank_at = blank_a; end
    end
    n_checks++;
    if (dones != 1 || falls != 1) begin
      n_fail++; $display("FAIL ignore_count: got dones=%0d falls=%0d, want 1 1", dones, falls);
    end
    n_checks++;
    if ({bcd_at, blank_at} !== {12'h042, BL_TWO}) begin
      n_fail++; $display("FAIL ignore_value: got bcd=%h blank=%b, want 042 %b", bcd_at, blank_at, BL_TWO);
    end
  endtask

  task automatic test_rst_abort();
    int dones, n, bc;
    bin_a = 8'd137; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1; start_a = 1'b1; bin_a = 8'd55;
    tick();
    rst = 1'b0; start_a = 1'b0;
    n_checks++;
    if ({busy_a, done_a, bcd_a, ovf_a, blank_a} !== 18'd0) begin
      n_fail++;
      $display("FAIL rst_abort: got busy=%b done=%b bcd=%h ovf=%b blank=%b, want all 0",
               busy_a, done_a, bcd_a, ovf_a, blank_a);
    end
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done_a || busy_a) dones++;
    end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL rst_no_done: got %0d active cycles, want 0", dones); end
    bin_a = 8'd9; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a(n, bc);
    n_checks++;
    if ({bcd_a, blank_a} !== {12'h009, BL_ONE} || n != 9) begin
      n_fail++;
      $display("FAIL after_rst: got bcd=%h blank=%b lat=%0d, want 009 %b 9", bcd_a, blank_a, n, BL_ONE);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n, bc, held_bad;
    bit seen;
    bin_a = 8'd100; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a(n, bc);
    n_checks++;
    if (bcd_a !== 12'h100 || n != 9) begin
      n_fail++; $display("FAIL b2b_first: got bcd=%h lat=%0d, want 100 9", bcd_a, n);
    end
    bin_a = 8'd63; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 1; seen = 0; held_bad = 0;
    if (done_a) seen = 1;
    while (!seen && n < 30) begin
      if (bcd_a !== 12'h100) held_bad++;
      tick(); n++;
      if (done_a) seen = 1;
    end
    n_checks++;
    if (!seen || n != 10) begin n_fail++; $display("FAIL b2b_spacing: got %0d, want 10", n); end
    n_checks++;
    if (held_bad != 0) begin n_fail++; $display("FAIL b2b_hold: got %0d changed cycles, want 0", held_bad); end
    n_checks++;
    if (bcd_a !== 12'h063) begin n_fail++; $display("FAIL b2b_second: got bcd=%h, want 063", bcd_a); end
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_convert_255();
    test_small_values();
    test_overflow();
    test_start_ignored();
    test_rst_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
